// File: rtl/zeroriscy_d_arb.sv
// zeroriscy_d_arb
//   Two-master arbiter in front of the data SRAM port. Master 0 is the core
//   LSU, master 1 is the host/loader. Accepted requests record their owner in
//   a small in-order FIFO so every rvalid/err is steered back to its issuer.
//
// Parameters
//   DEPTH : max outstanding accepted requests (owner FIFO depth, >= 1)
//
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   c_req/we/be/addr/wdata -> c_gnt  : core request, grant
//   c_rvalid/c_rdata/c_err           : core response
//   h_*                              : host port, same shape as core port
//   s_req/we/be/addr/wdata <- s_gnt  : SRAM request, grant
//   s_rvalid/s_rdata/s_err           : SRAM response
//   unexp                            : sticky, rvalid seen with nothing outstanding
//
// Build option
//   ZERORISCY_D_ARB_RR_EN : round-robin on conflict (default: core has priority)

module zeroriscy_d_arb #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [3:0]  c_be,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,
   output logic        c_err,
   input  logic        h_req,
   input  logic        h_we,
   input  logic [3:0]  h_be,
   input  logic [31:0] h_addr,
   input  logic [31:0] h_wdata,
   output logic        h_gnt,
   output logic        h_rvalid,
   output logic [31:0] h_rdata,
   output logic        h_err,
   output logic        s_req,
   output logic        s_we,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_gnt,
   input  logic        s_rvalid,
   input  logic [31:0] s_rdata,
   input  logic        s_err,
   output logic        unexp
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [DEPTH-1:0] owner_q;
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             last_q, unexp_q;

   logic win, full, empty, accept, pop, head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Winner: 0 = core, 1 = host. With no request the core fields are muxed out.
   always_comb begin
      win = 1'b0;
      if (h_req && !c_req) begin
         win = 1'b1;
      end else if (h_req && c_req) begin
`ifdef ZERORISCY_D_ARB_RR_EN
         win = ~last_q;
`else
         // Fixed priority: last is tracked but never steers the choice.
         win = last_q & 1'b0;
`endif
      end
   end

   assign full   = (cnt_q == FULL_CNT);
   assign empty  = (cnt_q == '0);
   // Full blocks even when a pop lands in the same cycle, so s_rvalid never
   // reaches s_req combinationally.
   assign s_req  = (c_req | h_req) & ~full;
   assign s_we   = win ? h_we    : c_we;
   assign s_be   = win ? h_be    : c_be;
   assign s_addr = win ? h_addr  : c_addr;
   assign s_wdata= win ? h_wdata : c_wdata;

   assign accept = s_req & s_gnt;
   assign c_gnt  = accept & ~win;
   assign h_gnt  = accept &  win;

   assign head     = owner_q[rptr_q];
   assign pop      = s_rvalid & ~empty;
   assign c_rvalid = pop & ~head;
   assign h_rvalid = pop &  head;
   assign c_err    = pop & ~head & s_err;
   assign h_err    = pop &  head & s_err;
   assign c_rdata  = s_rdata;
   assign h_rdata  = s_rdata;
   assign unexp    = unexp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b1;   // core wins the first conflict under round-robin
         unexp_q <= 1'b0;
      end else begin
         if (accept) begin
            owner_q[wptr_q] <= win;
            wptr_q          <= ptr_inc(wptr_q);
            last_q          <= win;
         end
         if (pop) rptr_q <= ptr_inc(rptr_q);
         case ({accept, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (s_rvalid && empty) unexp_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_zeroriscy_d_arb.sv
// Self-checking bench for zeroriscy_d_arb (DEPTH = 2). Expected responses are
// pushed to a scoreboard queue when a grant is expected and popped when the
// bench returns an SRAM rvalid. Inputs change 1 ns after posedge; outputs are
// sampled at negedge.

module tb_zeroriscy_d_arb;

   typedef struct {
      logic        owner;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        c_req, c_we, h_req, h_we;
   logic [3:0]  c_be, h_be, s_be;
   logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
   logic        c_gnt, c_rvalid, c_err, h_gnt, h_rvalid, h_err;
   logic [31:0] c_rdata, h_rdata;
   logic        s_req, s_we, s_gnt, s_rvalid, s_err, unexp;
   logic [31:0] s_addr, s_wdata, s_rdata;

   int   checks = 0, errors = 0;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   zeroriscy_d_arb #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
      .h_req(h_req), .h_we(h_we), .h_be(h_be), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
      .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
      .unexp(unexp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus, then move to the sampling point (negedge).
   task automatic drive(input logic creq, input logic hreq, input logic sgnt,
                        input logic srv, input logic [31:0] rdata, input logic serr);
      c_req = creq; h_req = hreq; s_gnt = sgnt;
      s_rvalid = srv; s_rdata = rdata; s_err = serr;
      #4;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c_we = 1'b0; c_be = 4'hF; c_addr = 32'h0000_0100; c_wdata = 32'h1111_1111;
      h_we = 1'b1; h_be = 4'h3; h_addr = 32'h0000_0200; h_wdata = 32'h2222_2222;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL reset_unexp got=%b exp=0", unexp); end
      checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL reset_sreq got=%b exp=1", s_req); end
      checks++; if (s_addr !== 32'h100 || s_be !== 4'hF) begin errors++; $display("FAIL reset_core_first got=%h/%h exp=100/f", s_addr, s_be); end
      checks++; if (c_gnt !== 1'b0 || h_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", c_gnt, h_gnt); end
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (s_req !== 1'b0 || c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL idle_outputs got=%b%b%b exp=000", s_req, c_rvalid, h_rvalid); end
      tick();
   endtask

   task automatic test_core_read();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin errors++; $display("FAIL core_read_gnt got=%b%b exp=10", c_gnt, h_gnt); end
      checks++; if (s_addr !== 32'h100 || s_we !== 1'b0 || s_wdata !== 32'h1111_1111) begin errors++; $display("FAIL core_read_fields got=%h/%b exp=100/0", s_addr, s_we); end
      sb.push_back('{owner: 1'b0, data: 32'hDEAD_BEEF, err: 1'b0});
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      e = sb.pop_front();
      checks++; if (c_rvalid !== ~e.owner || h_rvalid !== e.owner || c_rdata !== e.data) begin errors++; $display("FAIL core_read_resp got=%b%b %h exp=%b%b %h", c_rvalid, h_rvalid, c_rdata, ~e.owner, e.owner, e.data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic expw;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         drive(i < 6, i < 6, 1'b1, i > 0, 32'hA000_0000 + 32'(i - 1), 1'(i % 2));
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (c_rvalid !== ~e.owner || h_rvalid !== e.owner || h_rdata !== e.data ||
                c_err !== (~e.owner & e.err) || h_err !== (e.owner & e.err)) begin
               errors++;
               $display("FAIL b2b_resp%0d got=%b%b err=%b%b exp=%b%b err=%b", i, c_rvalid, h_rvalid, c_err, h_err, ~e.owner, e.owner, e.err);
            end
         end
         if (i < 6) begin
`ifdef ZERORISCY_D_ARB_RR_EN
            expw = 1'(i % 2);
`else
            expw = 1'b0;
`endif
            checks++;
            if (c_gnt !== ~expw || h_gnt !== expw || s_addr !== (expw ? 32'h200 : 32'h100)) begin
               errors++;
               $display("FAIL b2b_gnt%0d got=%b%b %h exp=%b%b", i, c_gnt, h_gnt, s_addr, ~expw, expw);
            end
            sb.push_back('{owner: expw, data: 32'hA000_0000 + 32'(i), err: 1'(i % 2 == 0)});
         end
         tick();
      end
   endtask

   task automatic test_full();
      // cycles 0,1 accept; 2 blocked; 3 blocked despite pop; 4 accepts again
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b1, i == 3, 32'hB000_0000, 1'b0);
         if (i == 3) begin
            e = sb.pop_front();
            checks++; if (c_rvalid !== ~e.owner || c_rdata !== e.data) begin errors++; $display("FAIL full_pop got=%b %h exp=%b %h", c_rvalid, c_rdata, ~e.owner, e.data); end
         end
         checks++;
         if (c_gnt !== (i < 2 || i == 4) || s_req !== (i < 2 || i == 4)) begin
            errors++;
            $display("FAIL full_gnt%0d got=%b/%b exp=%b", i, c_gnt, s_req, (i < 2 || i == 4));
         end
         if (i < 2 || i == 4) sb.push_back('{owner: 1'b0, data: 32'hB000_0000, err: 1'b0});
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 1'b0);
         e = sb.pop_front();
         checks++; if (c_rvalid !== ~e.owner || h_rvalid !== e.owner) begin errors++; $display("FAIL full_drain%0d got=%b%b exp=%b%b", i, c_rvalid, h_rvalid, ~e.owner, e.owner); end
         tick();
      end
   endtask

   task automatic test_no_gnt();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, i == 3, 1'b0, 32'h0, 1'b0);
         checks++; if (c_gnt !== (i == 3) || s_req !== 1'b1) begin errors++; $display("FAIL nognt%0d got=%b/%b exp=%b/1", i, c_gnt, s_req, i == 3); end
         if (i == 3) sb.push_back('{owner: 1'b0, data: 32'hC0DE_0001, err: 1'b0});
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0001, 1'b0);
      e = sb.pop_front();
      checks++; if (c_rvalid !== ~e.owner || c_rdata !== e.data) begin errors++; $display("FAIL nognt_resp got=%b %h exp=%b %h", c_rvalid, c_rdata, ~e.owner, e.data); end
      tick();
      // Only one entry may have been pushed: a second rvalid is unexpected.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL nognt_extra got=%b exp=0", c_rvalid); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (unexp !== 1'b1) begin errors++; $display("FAIL nognt_unexp got=%b exp=1", unexp); end
      tick();
   endtask

   task automatic test_unexp();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL unexp_pre got=%b exp=0", unexp); end
      checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0 || c_err !== 1'b0 || h_err !== 1'b0) begin errors++; $display("FAIL unexp_rvalid got=%b%b%b%b exp=0000", c_rvalid, h_rvalid, c_err, h_err); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         checks++; if (unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky%0d got=%b exp=1", i, unexp); end
         tick();
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (unexp !== 1'b0) begin errors++; $display("FAIL unexp_cleared got=%b exp=0", unexp); end
      tick();
   endtask

   task automatic test_reset_inflight();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (h_gnt !== 1'b1 || c_gnt !== 1'b0 || s_we !== 1'b1 || s_addr !== 32'h200 || s_be !== 4'h3 || s_wdata !== 32'h2222_2222) begin errors++; $display("FAIL host_write got=%b%b %b %h exp=01 1 200", c_gnt, h_gnt, s_we, s_addr); end
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      checks++; if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_rvalid got=%b%b exp=00", c_rvalid, h_rvalid); end
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (unexp !== 1'b1) begin errors++; $display("FAIL inflight_unexp got=%b exp=1", unexp); end
      checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL inflight_next_gnt got=%b exp=1", c_gnt); end
      sb.push_back('{owner: 1'b0, data: 32'h5555_AAAA, err: 1'b1});
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1);
      e = sb.pop_front();
      checks++; if (c_rvalid !== ~e.owner || c_rdata !== e.data || c_err !== e.err || h_err !== 1'b0) begin errors++; $display("FAIL inflight_next_resp got=%b %h err=%b%b exp=%b %h err=%b0", c_rvalid, c_rdata, c_err, h_err, ~e.owner, e.data, e.err); end
      tick();
   endtask

   initial begin
      c_req = 0; h_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = '0; s_err = 0;
      #1;
      test_reset();
      test_core_read();
      test_back_to_back();
      test_full();
      test_no_gnt();
      test_unexp();
      test_reset_inflight();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/zeroriscy_d_arb.md
# zeroriscy_d_arb

Two-master arbiter in front of the data SRAM port. It merges the core LSU data port (master 0) and the host/loader port (master 1) onto the single OBI-style data-memory slave port. It tracks the owner of every accepted request in a small in-order FIFO and routes each `rvalid`/`err` back to the master that issued the request. Back-to-back accesses run at full throughput against a one-cycle-latency memory.

## Interface
Parameters:
- `DEPTH`, 2: max outstanding accepted requests (owner FIFO depth, ≥1).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `c_req` in 1: core request valid; `c_we` in 1; `c_be` in 4; `c_addr` in 32; `c_wdata` in 32.
- `c_gnt` out 1: core request accepted this cycle.
- `c_rvalid` out 1; `c_rdata` out 32; `c_err` out 1: core response.
- `h_req`, `h_we`, `h_be`, `h_addr`, `h_wdata`, `h_gnt`, `h_rvalid`, `h_rdata`, `h_err`: host port, same widths and meanings as the core port.
- `s_req` out 1; `s_we` out 1; `s_be` out 4; `s_addr` out 32; `s_wdata` out 32: to the SRAM.
- `s_gnt` in 1; `s_rvalid` in 1; `s_rdata` in 32; `s_err` in 1: from the SRAM.
- `unexp` out 1: sticky flag, `s_rvalid` seen with no outstanding request.

## Operation
- State: owner FIFO (DEPTH entries × 1 bit, read/write pointers, count 0..DEPTH), `last` (1 bit, last granted master), `unexp` (1 bit).
- Winner selection, combinational:
  - If only one master requests, that master wins.
  - If both request, the winner is given by the arbitration policy (see Configuration).
- `s_req = (c_req | h_req) & ~full`. The `s_we/be/addr/wdata` fields are muxed from the winner. When no master requests, the fields are driven from master 0.
- Accept happens when `s_req & s_gnt`:
  - assert `gnt` to the winner only; the loser's `gnt` = 0;
  - push the winner id (0 = core, 1 = host) into the FIFO;
  - update `last` to the winner id.
- A full FIFO blocks new requests even if a pop occurs in the same cycle. There is no combinational path from `s_rvalid` to `s_req`.
- Response handling, on `s_rvalid`:
  - pop the FIFO head and assert `c_rvalid` or `h_rvalid` according to the head value;
  - route `s_err` only to that master's `err`.
- `c_rdata` and `h_rdata` are both driven directly from `s_rdata`.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Unexpected response (`s_rvalid` with an empty FIFO):
  - no `rvalid` is asserted to either master;
  - the FIFO is unchanged;
  - `unexp` is set and holds until `rst`.
- Pointers wrap modulo DEPTH. Responses are strictly in order.
- Writes also receive an `rvalid` (the SRAM returns `rvalid` for every accepted request), and it is routed the same way as for reads.

## Timing
- Reset values: FIFO empty (count 0, pointers 0), `last` = 1 (so the core wins the first conflict), `unexp` = 0.
- Output values during and after reset follow from that state:
  - `s_req` = `c_req|h_req`;
  - `c_gnt`, `h_gnt` reflect arbitration;
  - `c_rvalid`, `h_rvalid`, `c_err`, `h_err` = 0 unless `s_rvalid` arrives with a non-empty FIFO (impossible immediately after reset).
- Reset mid-operation: all state clears. Responses still in flight afterwards are treated as unexpected and set `unexp`.
- Request path is zero-latency combinational: master `req` → `s_req`, `s_gnt` → master `gnt`.
- Response path is zero-latency combinational: `s_rvalid` → master `rvalid`.
- A master must hold its request fields stable until it sees `gnt`.
- With the default DEPTH = 2 and one-cycle SRAM latency, one request is accepted every cycle. With DEPTH = 1, acceptance is at most one every 2 cycles.

## Configuration
- `ZERORISCY_D_ARB_RR_EN` defined: round-robin. On conflict, the master that is not `last` wins, so masters alternate while both request continuously.
- Not defined: fixed priority. On conflict the core always wins. `last` is still maintained but does not affect arbitration.

## Test plan
- Core-only read at `c_addr` = 0x100, SRAM returns 0xDEADBEEF one cycle later:
  - `c_gnt` = 1 in cycle 0;
  - `c_rvalid` = 1 with `c_rdata` = 0xDEADBEEF in cycle 1;
  - `h_rvalid` = 0 throughout.
- Both masters request continuously for 6 cycles, back-to-back with `s_gnt` = 1:
  - with RR_EN, grants are C,H,C,H,C,H;
  - without RR_EN, grants are C×6 and `h_gnt` = 0;
  - each `rvalid` goes to the matching owner one cycle later.
- DEPTH = 2 with `s_gnt` = 1 and `s_rvalid` held low:
  - two requests are accepted, then `s_req` = 0 and `gnt` = 0 on the third;
  - after one `s_rvalid`, the next cycle accepts again.
- `s_gnt` = 0 for 3 cycles with `c_req` held:
  - `c_gnt` = 0 and no FIFO push during those cycles;
  - accepted in the cycle `s_gnt` = 1.
- `s_rvalid` pulse with an empty FIFO:
  - neither `rvalid` asserts and `unexp` = 1 from the next cycle;
  - `unexp` stays 1 until `rst`, then returns to 0.
- Host write outstanding, `rst` asserted for 1 cycle, then the SRAM `rvalid` arrives:
  - no master `rvalid` asserts and `unexp` = 1;
  - the next core request is accepted normally.
